// File: rtl/pe_mac_lanes.sv
// pe_mac_lanes: multi-lane signed MAC processing element with convolution and fixed-MAC modes
module pe_mac_lanes #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int MUL_LAT    = 2,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst,
    input  logic                        cmd_valid,
    input  logic [3:0]                  cmd,
    input  logic [LEN_WIDTH-1:0]        param_in,
    input  logic [DATA_WIDTH-1:0]       coef_in,
    input  logic [LANES*DATA_WIDTH-1:0] data_in,
    input  logic [LANES*DATA_WIDTH-1:0] weight_in,
    output logic [LANES*DATA_WIDTH-1:0] data_out,
    output logic [LANES*DATA_WIDTH-1:0] weight_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [LANES*ACC_WIDTH-1:0]  res_data,
    output logic                        busy,
    output logic                        sat,
    output logic                        overrun
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [3:0] C_RESET = 4'd0;
    localparam logic [3:0] C_TRIG  = 4'd1;
    localparam logic [3:0] C_MUL   = 4'd2;
    localparam logic [3:0] C_ADD   = 4'd3;
    localparam logic [3:0] C_CONV  = 4'd4;
    localparam logic [3:0] C_FIX   = 4'd5;
    localparam logic [3:0] C_FWD   = 4'd6;

    typedef enum logic {CONV, FIX} mode_e;

    mode_e                       mode_q, mode_d;
    logic [LEN_WIDTH-1:0]        conv_len_q, conv_len_d, cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       mul_q, mul_d, add_q, add_d;
    logic [LANES*DATA_WIDTH-1:0] data_q, data_d, weight_q, weight_d;
    logic [MUL_LAT-1:0]          vld_q, vld_d;
    logic [LANES*ACC_WIDTH-1:0]  res_q, res_d;
    logic                        res_valid_q, res_valid_d, busy_q, busy_d;
    logic                        sat_q, sat_d, overrun_q, overrun_d;
    logic [LANES-1:0]            clamp;
    logic                        do_reset, do_trig, do_pass, set_ok, retire, last, new_res;

    assign do_reset = cmd_valid && cmd == C_RESET;
    assign do_trig  = cmd_valid && cmd == C_TRIG;
    assign do_pass  = do_trig || (cmd_valid && cmd == C_FWD);
    assign set_ok   = cmd_valid && !busy_q;
    // A RESET command drops whatever product is retiring in the same cycle.
    assign retire   = vld_q[MUL_LAT-1] && !do_reset;
    assign last     = mode_q == FIX || cnt_q + LEN_WIDTH'(1) == conv_len_q;
    assign new_res  = retire && last;

    // Next state of configuration, pipeline valids, count and result flags.
    always_comb begin
        mode_d      = set_ok && cmd == C_CONV ? CONV : set_ok && cmd == C_FIX ? FIX : mode_q;
        conv_len_d  = set_ok && cmd == C_CONV ? (param_in == '0 ? LEN_WIDTH'(1) : param_in) : conv_len_q;
        mul_d       = set_ok && cmd == C_MUL ? coef_in : mul_q;
        add_d       = set_ok && cmd == C_ADD ? coef_in : add_q;
        data_d      = do_pass ? data_in : data_q;
        weight_d    = do_pass ? weight_in : weight_q;
        vld_d       = do_reset ? '0 : MUL_LAT'({vld_q, do_trig});
        cnt_d       = do_reset || new_res ? '0 : retire ? cnt_q + LEN_WIDTH'(1) : cnt_q;
        res_valid_d = !do_reset && (new_res || (res_valid_q && !res_ready));
        overrun_d   = !do_reset && (overrun_q || (new_res && res_valid_q && !res_ready));
        sat_d       = !do_reset && (sat_q || |clamp);
        busy_d      = !do_reset && (do_trig || |vld_q || cnt_q != '0);
    end

    // Shared control and output registers.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            mode_q      <= CONV;
            conv_len_q  <= LEN_WIDTH'(1);
            cnt_q       <= '0;
            mul_q       <= '0;
            add_q       <= '0;
            data_q      <= '0;
            weight_q    <= '0;
            vld_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            conv_len_q  <= conv_len_d;
            cnt_q       <= cnt_d;
            mul_q       <= mul_d;
            add_q       <= add_d;
            data_q      <= data_d;
            weight_q    <= weight_d;
            vld_q       <= vld_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            sat_q       <= sat_d;
            overrun_q   <= overrun_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] a, b;
        logic signed [PW-1:0]         p, r;
        logic [MUL_LAT*PW-1:0]        pipe_q, pipe_d;
        logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, base, sum_sat;
        logic signed [ACC_WIDTH:0]    sum;
        logic                         ovf;
        assign a       = data_in[l*DATA_WIDTH +: DATA_WIDTH];
        assign b       = mode_q == FIX ? mul_q : weight_in[l*DATA_WIDTH +: DATA_WIDTH];
        assign p       = PW'(a) * PW'(b);
        // Newest product enters at the bottom; the top slot is the retiring one.
        assign pipe_d  = (MUL_LAT*PW)'({pipe_q, p});
        assign r       = pipe_q[(MUL_LAT-1)*PW +: PW];
        assign base    = mode_q == FIX ? ACC_WIDTH'($signed(add_q)) : acc_q;
        assign sum     = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(r);
        assign ovf     = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
        assign sum_sat = ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){!sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
        assign clamp[l] = retire && ovf;
        assign acc_d   = do_reset || new_res ? '0 : retire ? sum_sat : acc_q;
        assign res_d[l*ACC_WIDTH +: ACC_WIDTH] = new_res ? sum_sat : res_q[l*ACC_WIDTH +: ACC_WIDTH];

        // Lane multiplier pipeline and running accumulator.
        always_ff @(posedge clk_i) begin
            if (rst) begin
                pipe_q <= '0;
                acc_q  <= '0;
            end else begin
                pipe_q <= pipe_d;
                acc_q  <= acc_d;
            end
        end
    end

    assign data_out   = data_q;
    assign weight_out = weight_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_q;
    assign busy       = busy_q;
    assign sat        = sat_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_pe_mac_lanes.sv
// tb_pe_mac_lanes: directed table-driven bench for the multi-lane MAC element
module tb_pe_mac_lanes;
    localparam int L  = 4;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam logic [3:0] K_RST  = 4'd0;
    localparam logic [3:0] K_TRG  = 4'd1;
    localparam logic [3:0] K_MUL  = 4'd2;
    localparam logic [3:0] K_ADD  = 4'd3;
    localparam logic [3:0] K_CONV = 4'd4;
    localparam logic [3:0] K_FIX  = 4'd5;
    localparam logic [3:0] K_FWD  = 4'd6;

    logic          clk_i = 1'b0;
    logic          rst, cmd_valid, res_ready, res_valid, busy, sat, overrun;
    logic [3:0]    cmd;
    logic [15:0]   param_in, coef_in;
    logic [L*DW-1:0] data_in, weight_in, data_out, weight_out;
    logic [L*AW-1:0] res_data;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [L*DW-1:0] data;
        logic [L*AW-1:0] exp;
    } vec_t;
    vec_t tbl [4];

    pe_mac_lanes dut (
        .clk_i(clk_i), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .param_in(param_in), .coef_in(coef_in), .data_in(data_in), .weight_in(weight_in),
        .data_out(data_out), .weight_out(weight_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .busy(busy), .sat(sat), .overrun(overrun)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    function automatic logic [L*DW-1:0] dv(int a, int b, int c, int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [L*AW-1:0] rv(longint a, longint b, longint c, longint d);
        return {AW'(d), AW'(c), AW'(b), AW'(a)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input logic [L*AW-1:0] act, input logic [L*AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [L*DW-1:0] d, input logic [L*DW-1:0] w,
                         input logic [15:0] prm, input logic [15:0] cf);
        cmd_valid = 1'b1;
        cmd       = c;
        data_in   = d;
        weight_in = w;
        param_in  = prm;
        coef_in   = cf;
        tick();
        cmd_valid = 1'b0;
        cmd       = 4'd0;
    endtask

    task automatic trig(input logic [L*DW-1:0] d, input logic [L*DW-1:0] w);
        issue(K_TRG, d, w, 16'd0, 16'd0);
    endtask

    task automatic setc(input logic [3:0] c, input logic [15:0] prm, input logic [15:0] cf);
        issue(c, '0, '0, prm, cf);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_res_valid", res_valid, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    initial begin
        longint mx, mn;
        mx = (longint'(1) << 39) - 1;
        mn = -(longint'(1) << 39);
        tbl[0] = '{dv(7, -2, 0, 32767),      rv(11, -16, -10, 98291)};
        tbl[1] = '{dv(1, 1, 1, 1),           rv(-7, -7, -7, -7)};
        tbl[2] = '{dv(-32768, 100, -1, 5),   rv(-98314, 290, -13, 5)};
        tbl[3] = '{dv(10000, -10000, 3, -3), rv(29990, -30010, -1, -19)};

        rst = 1'b1; cmd_valid = 1'b0; cmd = 4'd0; param_in = '0; coef_in = '0;
        data_in = '0; weight_in = '0; res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        check("rst_overrun", overrun, 0);
        check("rst_res_data", res_data, 0);
        check("rst_data_out", data_out, 0);
        check("rst_weight_out", weight_out, 0);

        // default conv_len=1 after rst: single product per result
        trig(dv(2, -3, 4, 1), dv(3, 3, -5, 0));
        tick();
        check("dflt_early", res_valid, 0);
        tick();
        check("dflt_valid", res_valid, 1);
        check("dflt_data", res_data, rv(6, -9, -20, 0));
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // convolution: conv_len=3, three back-to-back triggers
        wait_idle(10);
        setc(K_CONV, 16'd3, 16'd0);
        repeat (3) trig(dv(1, 2, 3, 4), dv(5, 6, 7, 8));
        check("conv_t3_valid", res_valid, 0);
        check("conv_t3_busy", busy, 1);
        tick();
        check("conv_t4_valid", res_valid, 0);
        tick();
        check("conv_t5_valid", res_valid, 1);
        check("conv_t5_data", res_data, rv(15, 36, 63, 96));
        check("conv_t5_busy", busy, 1);
        tick();
        check("conv_t6_busy", busy, 0);
        check("conv_t6_hold", res_valid, 1);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("conv_consumed", res_valid, 0);

        // fixed-MAC table: mul=3, add=-10, weight_in ignored for arithmetic
        setc(K_MUL, 16'd0, 16'd3);
        setc(K_ADD, 16'd0, 16'hFFF6);
        setc(K_FIX, 16'd0, 16'd0);
        res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) trig(tbl[c].data, dv(9, 9, 9, 9));
            else tick();
            if (c == 0) begin
                check("fix_weight_out", weight_out, dv(9, 9, 9, 9));
                check("fix_data_out", data_out, tbl[0].data);
            end
            if (c >= 2 && c <= 5) begin
                check($sformatf("fix_valid_%0d", c - 2), res_valid, 1);
                check($sformatf("fix_data_%0d", c - 2), res_data, tbl[c - 2].exp);
            end else begin
                check($sformatf("fix_idle_%0d", c), res_valid, 0);
            end
        end
        check("fix_overrun", overrun, 0);
        res_ready = 1'b0;

        // positive and negative saturation over 600 products
        wait_idle(10);
        setc(K_CONV, 16'd600, 16'd0);
        repeat (600) trig(dv(32767, 32767, 32767, 32767), dv(32767, 32767, 32767, 32767));
        wait_valid(10);
        check("satp_data", res_data, rv(mx, mx, mx, mx));
        check("satp_flag", sat, 1);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        setc(K_RST, 16'd0, 16'd0);
        check("reset_sat", sat, 0);
        check("reset_valid", res_valid, 0);
        repeat (600) trig(dv(-32768, -32768, -32768, -32768), dv(32767, 32767, 32767, 32767));
        wait_valid(10);
        check("satn_data", res_data, rv(mn, mn, mn, mn));
        check("satn_flag", sat, 1);
        setc(K_RST, 16'd0, 16'd0);

        // backpressure and overrun
        setc(K_CONV, 16'd1, 16'd0);
        trig(dv(2, 2, 2, 2), dv(1, 1, 1, 1));
        trig(dv(5, 5, 5, 5), dv(1, 1, 1, 1));
        tick();
        check("bp_first_valid", res_valid, 1);
        check("bp_first_data", res_data, rv(2, 2, 2, 2));
        check("bp_first_ovr", overrun, 0);
        tick();
        check("bp_second_valid", res_valid, 1);
        check("bp_second_data", res_data, rv(5, 5, 5, 5));
        check("bp_second_ovr", overrun, 1);
        trig(dv(7, 7, 7, 7), dv(1, 1, 1, 1));
        tick();
        res_ready = 1'b1;
        tick();
        check("bp_hs_valid", res_valid, 1);
        check("bp_hs_data", res_data, rv(7, 7, 7, 7));
        check("bp_hs_ovr", overrun, 1);
        tick();
        check("bp_drained", res_valid, 0);
        res_ready = 1'b0;
        setc(K_RST, 16'd0, 16'd0);
        check("bp_reset_ovr", overrun, 0);
        trig(dv(3, 3, 3, 3), dv(1, 1, 1, 1));
        trig(dv(4, 4, 4, 4), dv(1, 1, 1, 1));
        tick();
        check("hs_first_data", res_data, rv(3, 3, 3, 3));
        res_ready = 1'b1;
        tick();
        check("hs_load_valid", res_valid, 1);
        check("hs_load_data", res_data, rv(4, 4, 4, 4));
        check("hs_load_ovr", overrun, 0);
        tick();
        check("hs_drained", res_valid, 0);
        res_ready = 1'b0;

        // RESET command with products in flight
        wait_idle(10);
        setc(K_CONV, 16'd4, 16'd0);
        trig(dv(5, 5, 5, 5), dv(1, 1, 1, 1));
        trig(dv(5, 5, 5, 5), dv(1, 1, 1, 1));
        setc(K_RST, 16'd0, 16'd0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_valid", res_valid, 0);
        repeat (5) tick();
        check("mid_reset_quiet", res_valid, 0);
        repeat (4) trig(dv(1, 1, 1, 1), dv(1, 1, 1, 1));
        tick();
        check("mid_after_early", res_valid, 0);
        tick();
        check("mid_after_valid", res_valid, 1);
        check("mid_after_data", res_data, rv(4, 4, 4, 4));
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // FORWARD, SET while busy and no-op code
        wait_idle(10);
        trig(dv(1, 1, 1, 1), dv(1, 1, 1, 1));
        trig(dv(1, 1, 1, 1), dv(1, 1, 1, 1));
        setc(K_FIX, 16'd0, 16'd0);
        issue(K_FWD, dv('hAAAA, 'hAAAA, 'hAAAA, 'hAAAA), dv('h5555, 'h5555, 'h5555, 'h5555), 16'd0, 16'd0);
        check("fwd_data_out", data_out, dv('hAAAA, 'hAAAA, 'hAAAA, 'hAAAA));
        check("fwd_weight_out", weight_out, dv('h5555, 'h5555, 'h5555, 'h5555));
        check("fwd_no_result", res_valid, 0);
        issue(4'd9, dv('h1234, 'h1234, 'h1234, 'h1234), dv(1, 1, 1, 1), 16'd0, 16'd0);
        check("nop_data_hold", data_out, dv('hAAAA, 'hAAAA, 'hAAAA, 'hAAAA));
        trig(dv(1, 1, 1, 1), dv(1, 1, 1, 1));
        trig(dv(1, 1, 1, 1), dv(1, 1, 1, 1));
        tick();
        check("fwd_sum_early", res_valid, 0);
        tick();
        check("fwd_sum_valid", res_valid, 1);
        check("fwd_sum_data", res_data, rv(4, 4, 4, 4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
